// File: rtl/find_corners.sv
// find_corners: scans outward from a card centre in a thresholded frame
// buffer (single-port RAM, 1-cycle read latency) and reports the card's
// right, left, top and bottom edges along the centre row/column.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for find_corners_flag
// SCAN_RIGHT | probing centre row, x increasing
// SCAN_LEFT  | probing centre row, x decreasing
// SCAN_UP    | probing centre column, y decreasing
// SCAN_DOWN  | probing centre column, y increasing
// DONE       | data_valid_out high for one cycle
//
// Each scan state alternates ISSUE (r_check=0, address on addr_out) and
// CHECK (r_check=1, RAM data valid on pixel_data_in).
module find_corners #(
    parameter int HEIGHT = 320,
    parameter int WIDTH  = 240
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        find_corners_flag,
    input  logic [7:0]  x_center,
    input  logic [8:0]  y_center,
    input  logic [15:0] pixel_data_in,
    output logic [16:0] addr_out,
    output logic        data_valid_out,
    output logic [7:0]  right_edge,
    output logic [7:0]  left_edge,
    output logic [8:0]  top_edge,
    output logic [8:0]  bot_edge
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_RIGHT,
        SCAN_LEFT,
        SCAN_UP,
        SCAN_DOWN,
        DONE
    } state_t;

    state_t      r_state;
    logic        r_check;
    logic [7:0]  r_x;
    logic [8:0]  r_y;
    logic [7:0]  r_xc;
    logic [8:0]  r_yc;
    logic [16:0] r_center;
    logic [16:0] r_addr;
    logic        r_valid;
    logic [7:0]  r_right;
    logic [7:0]  r_left;
    logic [8:0]  r_top;
    logic [8:0]  r_bot;

    logic        w_card;
    logic [7:0]  w_xc;
    logic [8:0]  w_yc;
    logic [16:0] w_center;

    // Clamp the requested centre into the frame so no address can leave it.
    always_comb begin
        w_xc     = (x_center >= 8'(WIDTH))  ? 8'(WIDTH - 1)  : x_center;
        w_yc     = (y_center >= 9'(HEIGHT)) ? 9'(HEIGHT - 1) : y_center;
        w_center = 17'(w_yc) * 17'(WIDTH) + 17'(w_xc);
        w_card   = (pixel_data_in != 16'h0000);
    end

    // Scan sequencer; consecutive probes step the address by +-1 or +-WIDTH
    // so only the centre address needs a multiply.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= IDLE;
            r_check  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_xc     <= '0;
            r_yc     <= '0;
            r_center <= '0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_right  <= '0;
            r_left   <= '0;
            r_top    <= '0;
            r_bot    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (find_corners_flag) begin
                        r_xc     <= w_xc;
                        r_yc     <= w_yc;
                        r_x      <= w_xc;
                        r_y      <= w_yc;
                        r_center <= w_center;
                        r_addr   <= w_center;
                        r_right  <= w_xc;
                        r_check  <= 1'b0;
                        r_state  <= SCAN_RIGHT;
                    end
                end
                SCAN_RIGHT: begin
                    if (!r_check) begin
                        r_check <= 1'b1;
                    end else if (w_card && r_x != 8'(WIDTH - 1)) begin
                        r_right <= r_x;
                        r_x     <= r_x + 8'd1;
                        r_addr  <= r_addr + 17'd1;
                        r_check <= 1'b0;
                    end else begin
                        if (w_card) r_right <= r_x;
                        r_x     <= r_xc;
                        r_addr  <= r_center;
                        r_left  <= r_xc;
                        r_check <= 1'b0;
                        r_state <= SCAN_LEFT;
                    end
                end
                SCAN_LEFT: begin
                    if (!r_check) begin
                        r_check <= 1'b1;
                    end else if (w_card && r_x != 8'd0) begin
                        r_left  <= r_x;
                        r_x     <= r_x - 8'd1;
                        r_addr  <= r_addr - 17'd1;
                        r_check <= 1'b0;
                    end else begin
                        if (w_card) r_left <= r_x;
                        r_x     <= r_xc;
                        r_y     <= r_yc;
                        r_addr  <= r_center;
                        r_top   <= r_yc;
                        r_check <= 1'b0;
                        r_state <= SCAN_UP;
                    end
                end
                SCAN_UP: begin
                    if (!r_check) begin
                        r_check <= 1'b1;
                    end else if (w_card && r_y != 9'd0) begin
                        r_top   <= r_y;
                        r_y     <= r_y - 9'd1;
                        r_addr  <= r_addr - 17'(WIDTH);
                        r_check <= 1'b0;
                    end else begin
                        if (w_card) r_top <= r_y;
                        r_y     <= r_yc;
                        r_addr  <= r_center;
                        r_bot   <= r_yc;
                        r_check <= 1'b0;
                        r_state <= SCAN_DOWN;
                    end
                end
                SCAN_DOWN: begin
                    if (!r_check) begin
                        r_check <= 1'b1;
                    end else if (w_card && r_y != 9'(HEIGHT - 1)) begin
                        r_bot   <= r_y;
                        r_y     <= r_y + 9'd1;
                        r_addr  <= r_addr + 17'(WIDTH);
                        r_check <= 1'b0;
                    end else begin
                        if (w_card) r_bot <= r_y;
                        r_check <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_check <= 1'b0;
                end
            endcase
        end
    end

    assign addr_out       = r_addr;
    assign data_valid_out = r_valid;
    assign right_edge     = r_right;
    assign left_edge      = r_left;
    assign top_edge       = r_top;
    assign bot_edge       = r_bot;

endmodule

// File: tb/tb_find_corners.sv
// Directed bench for find_corners with a behavioural 1-cycle-latency RAM
// whose contents are generated from a selectable frame pattern.
module tb_find_corners;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        find_corners_flag = 1'b0;
    logic [7:0]  x_center = '0;
    logic [8:0]  y_center = '0;
    logic [15:0] pixel_data_in = '0;
    logic [16:0] addr_out;
    logic        data_valid_out;
    logic [7:0]  right_edge;
    logic [7:0]  left_edge;
    logic [8:0]  top_edge;
    logic [8:0]  bot_edge;

    int n_total = 0;
    int n_pass  = 0;
    int mode    = 0;   // 0: rectangle x30..200 y40..290, 1: all zero, 2: all ones
    int valid_cnt = 0;
    int addr_hi   = 0;
    int seen_37074 = 0;

    find_corners dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .find_corners_flag (find_corners_flag),
        .x_center          (x_center),
        .y_center          (y_center),
        .pixel_data_in     (pixel_data_in),
        .addr_out          (addr_out),
        .data_valid_out    (data_valid_out),
        .right_edge        (right_edge),
        .left_edge         (left_edge),
        .top_edge          (top_edge),
        .bot_edge          (bot_edge)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] frame_pix(input logic [16:0] a);
        int x;
        int y;
        x = int'(a) % 240;
        y = int'(a) / 240;
        if (mode == 1) return 16'h0000;
        if (mode == 2) return 16'hFFFF;
        if (x >= 30 && x <= 200 && y >= 40 && y <= 290) return 16'hFFFF;
        return 16'h0000;
    endfunction

    always @(posedge clk_in) begin
        pixel_data_in <= frame_pix(addr_out);
        if (data_valid_out) valid_cnt <= valid_cnt + 1;
        if (addr_out > 17'd76799) addr_hi <= addr_hi + 1;
        if (addr_out == 17'd37074) seen_37074 <= seen_37074 + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pulse_start(input int xc, input int yc);
        @(posedge clk_in); #1;
        x_center = 8'(xc);
        y_center = 9'(yc);
        find_corners_flag = 1'b1;
        @(posedge clk_in); #1;
        find_corners_flag = 1'b0;
    endtask

    // Waits up to 5000 cycles for data_valid_out; returns 1 if seen.
    task automatic wait_valid(output int found);
        found = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk_in); #1;
            if (data_valid_out) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input int xc, input int yc,
                                 input int er, input int el, input int et, input int eb);
        int found;
        int v0;
        v0 = valid_cnt;
        pulse_start(xc, yc);
        wait_valid(found);
        check({tag, "_valid_seen"}, found, 1);
        check({tag, "_right"}, int'(right_edge), er);
        check({tag, "_left"},  int'(left_edge),  el);
        check({tag, "_top"},   int'(top_edge),   et);
        check({tag, "_bot"},   int'(bot_edge),   eb);
        repeat (10) @(posedge clk_in);
        #1;
        check({tag, "_one_pulse"}, valid_cnt - v0, 1);
    endtask

    initial begin
        int found;
        int v0;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_addr",  int'(addr_out), 0);
        check("rst_valid", int'(data_valid_out), 0);
        check("rst_right", int'(right_edge), 0);
        check("rst_left",  int'(left_edge), 0);
        check("rst_top",   int'(top_edge), 0);
        check("rst_bot",   int'(bot_edge), 0);
        rst_in = 1'b0;

        // Card rectangle
        mode = 0;
        seen_37074 = 0;
        run_and_check("rect", 114, 153, 200, 30, 40, 290);
        check("addr_37074_seen", int'(seen_37074 > 0), 1);
        check("idle_addr_hold", int'(addr_out), 291 * 240 + 114);

        // All-zero frame: every edge collapses onto the centre
        mode = 1;
        run_and_check("zero", 114, 153, 114, 114, 153, 153);

        // All-card frame: edges hit the frame borders, no out-of-frame address
        mode = 2;
        addr_hi = 0;
        run_and_check("full", 114, 153, 239, 0, 0, 319);
        check("full_addr_range", addr_hi, 0);

        // Out-of-range centre clamps to the bottom-right pixel
        run_and_check("clamp_full", 250, 400, 239, 0, 0, 319);
        mode = 0;
        run_and_check("clamp_rect", 250, 400, 239, 239, 319, 319);

        // Second start mid-scan is ignored
        v0 = valid_cnt;
        pulse_start(114, 153);
        repeat (18) @(posedge clk_in);
        #1;
        find_corners_flag = 1'b1;
        x_center = 8'd10;
        y_center = 9'd10;
        @(posedge clk_in); #1;
        find_corners_flag = 1'b0;
        wait_valid(found);
        check("restart_valid_seen", found, 1);
        check("restart_right", int'(right_edge), 200);
        check("restart_left",  int'(left_edge),  30);
        check("restart_top",   int'(top_edge),   40);
        check("restart_bot",   int'(bot_edge),   290);
        repeat (10) @(posedge clk_in);
        #1;
        check("restart_one_pulse", valid_cnt - v0, 1);

        // Reset during SCAN_UP: (114,100) is only probed in the upward scan
        v0 = valid_cnt;
        pulse_start(114, 153);
        found = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk_in); #1;
            if (addr_out == 17'd24114) begin
                found = 1;
                break;
            end
        end
        check("scan_up_reached", found, 1);
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("midrst_right", int'(right_edge), 0);
        check("midrst_left",  int'(left_edge),  0);
        check("midrst_top",   int'(top_edge),   0);
        check("midrst_bot",   int'(bot_edge),   0);
        check("midrst_addr",  int'(addr_out),   0);
        repeat (600) @(posedge clk_in);
        #1;
        check("midrst_no_valid", valid_cnt - v0, 0);
        run_and_check("after_rst", 114, 153, 200, 30, 40, 290);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
